// File: rtl/bin_gray_counter_if.sv
// Control and result bundle for the binary/Gray up/down counter.
// Latency: none; a plain grouping of wires.
// Backpressure: none; the counter steps every cycle the master asserts en.
interface bin_gray_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc;
    logic             wrap_evt;
    logic             step_err;

    // Master drives the count controls and observes the results.
    modport master (
        output en, up, load, load_val,
        input  bin_q, gray_q, tc, wrap_evt, step_err
    );

    // Slave is the counter itself.
    modport slave (
        input  en, up, load, load_val,
        output bin_q, gray_q, tc, wrap_evt, step_err
    );
endinterface

// File: rtl/bin_gray_counter.sv
// Up/down binary counter with registered Gray output, wrap/saturate bounds and a Gray unit-distance checker.
// Latency: one clock from en/load to bin_q/gray_q/wrap_evt/step_err; tc is combinational.
// Backpressure: none; one step per cycle while en is high, load overrides en.
module bin_gray_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter bit WRAP    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bin_gray_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX  = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gry_q, gry_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             step;
    logic             wrapped;

    // True when exactly one bit is set: the Gray step moved a single bit.
    function automatic logic is_unit(input logic [WIDTH-1:0] x);
        return (x != ZERO) && ((x & (x - ONE)) == ZERO);
    endfunction

    // Next count: load (clamped) beats a count step, which beats hold.
    always_comb begin
        cnt_d   = cnt_q;
        step    = 1'b0;
        wrapped = 1'b0;
        if (bus.load) begin
            cnt_d = (bus.load_val > MAX) ? MAX : bus.load_val;
        end else if (bus.en) begin
            step = 1'b1;
            if (bus.up) begin
                if (cnt_q == MAX) begin
                    if (WRAP) begin
                        cnt_d   = ZERO;
                        wrapped = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == ZERO) begin
                    if (WRAP) begin
                        cnt_d   = MAX;
                        wrapped = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
        gry_d  = cnt_d ^ (cnt_d >> 1);
        wrap_d = wrapped;
        // Only real count steps are checked; saturated holds leave the value unchanged.
        err_d  = step && (cnt_d != cnt_q) && !is_unit(gry_q ^ gry_d);
    end

    // State and flag registers; reset overrides load and en.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= ZERO;
            gry_q  <= ZERO;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gry_q  <= gry_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.bin_q    = cnt_q;
    assign bus.gray_q   = gry_q;
    assign bus.wrap_evt = wrap_q;
    assign bus.step_err = err_q;
    assign bus.tc       = bus.up ? (cnt_q == MAX) : (cnt_q == ZERO);
endmodule

// File: tb/tb_bin_gray_counter.sv
// Directed bench for bin_gray_counter: full-range default, saturating and MAX_VAL=9 instances.
// Latency: expectations are queued at drive time and popped one clock later.
// Backpressure: none; one instance is stepped per cycle while the others idle.
module tb_bin_gray_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bin_gray_counter_if #(.WIDTH(4)) if_a ();
    bin_gray_counter_if #(.WIDTH(4)) if_s ();
    bin_gray_counter_if #(.WIDTH(4)) if_n ();

    bin_gray_counter #(.WIDTH(4), .MAX_VAL(15), .WRAP(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    bin_gray_counter #(.WIDTH(4), .MAX_VAL(15), .WRAP(1'b0)) u_s (.clk(clk), .rst(rst), .bus(if_s));
    bin_gray_counter #(.WIDTH(4), .MAX_VAL(9),  .WRAP(1'b1)) u_n (.clk(clk), .rst(rst), .bus(if_n));

    typedef struct {
        int       k;
        logic [3:0] bin;
        logic [3:0] gray;
        logic     wrap;
        logic     err;
    } exp_t;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic     tc;
        logic     wrap;
        logic     err;
    } obs_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mb[3];
    int   mx[3] = '{15, 15, 9};
    bit   mw[3] = '{1'b1, 1'b0, 1'b1};
    int   gtbl[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int k, output obs_t o);
        case (k)
            0:       o = '{if_a.bin_q, if_a.gray_q, if_a.tc, if_a.wrap_evt, if_a.step_err};
            1:       o = '{if_s.bin_q, if_s.gray_q, if_s.tc, if_s.wrap_evt, if_s.step_err};
            default: o = '{if_n.bin_q, if_n.gray_q, if_n.tc, if_n.wrap_evt, if_n.step_err};
        endcase
    endtask

    task automatic drive(input int k, input bit en, input bit up, input bit ld, input int lv);
        if_a.en = (k == 0) && en; if_a.up = up; if_a.load = (k == 0) && ld; if_a.load_val = 4'(lv);
        if_s.en = (k == 1) && en; if_s.up = up; if_s.load = (k == 1) && ld; if_s.load_val = 4'(lv);
        if_n.en = (k == 2) && en; if_n.up = up; if_n.load = (k == 2) && ld; if_n.load_val = 4'(lv);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        obs_t o;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        sample(e.k, o);
        chk({tag, "_bin"},  o.bin,  e.bin);
        chk({tag, "_gray"}, o.gray, e.gray);
        chk({tag, "_wrap"}, o.wrap, e.wrap);
        chk({tag, "_err"},  o.err,  e.err);
    endtask

    // One clock on instance k: check tc, predict, clock, compare.
    task automatic cyc(input string tag, input int k, input bit en, input bit up, input bit ld, input int lv);
        int   nb, go, gn;
        bit   st, wr, er;
        obs_t o;
        exp_t e;
        drive(k, en, up, ld, lv);
        #1;
        sample(k, o);
        chk({tag, "_tc"}, o.tc, up ? (mb[k] == mx[k]) : (mb[k] == 0));
        nb = mb[k]; st = 1'b0; wr = 1'b0;
        if (ld) begin
            nb = (lv > mx[k]) ? mx[k] : lv;
        end else if (en) begin
            st = 1'b1;
            if (up) begin
                if (mb[k] == mx[k]) begin
                    if (mw[k]) begin nb = 0; wr = 1'b1; end
                end else nb = mb[k] + 1;
            end else begin
                if (mb[k] == 0) begin
                    if (mw[k]) begin nb = mx[k]; wr = 1'b1; end
                end else nb = mb[k] - 1;
            end
        end
        go = mb[k] ^ (mb[k] >> 1);
        gn = nb ^ (nb >> 1);
        er = st && (nb != mb[k]) && ($countones(go ^ gn) != 1);
        mb[k] = nb;
        e = '{k, 4'(nb), 4'(gn), wr, er};
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    // Reset with load and en also high on every instance: reset must win.
    task automatic do_reset(input string tag);
        if_a.en = 1'b1; if_a.up = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd6;
        if_s.en = 1'b1; if_s.up = 1'b1; if_s.load = 1'b1; if_s.load_val = 4'd6;
        if_n.en = 1'b1; if_n.up = 1'b1; if_n.load = 1'b1; if_n.load_val = 4'd6;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            mb[k] = 0;
            e = '{k, 4'd0, 4'd0, 1'b0, 1'b0};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) pop_check(tag);
    endtask

    initial begin
        drive(0, 1'b0, 1'b1, 1'b0, 0);
        @(posedge clk);
        #1;
        do_reset("rst0");

        // 1: count up through the full range, Gray sequence from a fixed table.
        for (int i = 1; i <= 15; i++) begin
            cyc("t1", 0, 1'b1, 1'b1, 1'b0, 0);
            chk("t1_bin_tbl", if_a.bin_q, i);
            chk("t1_gray_tbl", if_a.gray_q, gtbl[i]);
            chk("t1_err_const", if_a.step_err, 0);
        end

        // 2: wrap 15 -> 0 going up, single-cycle wrap pulse.
        if_a.up = 1'b1; #1;
        chk("t2_tc_at15", if_a.tc, 1);
        cyc("t2_wrap", 0, 1'b1, 1'b1, 1'b0, 0);
        chk("t2_bin0", if_a.bin_q, 0);
        chk("t2_wrap_pulse", if_a.wrap_evt, 1);
        cyc("t2_idle", 0, 1'b0, 1'b1, 1'b0, 0);
        chk("t2_wrap_gone", if_a.wrap_evt, 0);

        // 3: wrap 0 -> 15 going down.
        if_a.up = 1'b0; #1;
        chk("t3_tc_at0_down", if_a.tc, 1);
        cyc("t3_wrap", 0, 1'b1, 1'b0, 1'b0, 0);
        chk("t3_bin15", if_a.bin_q, 15);
        chk("t3_gray", if_a.gray_q, 4'b1000);
        chk("t3_wrap_pulse", if_a.wrap_evt, 1);

        // 4: load beats en, then count down from the loaded value.
        cyc("t4_load", 0, 1'b1, 1'b1, 1'b1, 9);
        chk("t4_bin9", if_a.bin_q, 9);
        chk("t4_gray", if_a.gray_q, 4'b1101);
        chk("t4_err", if_a.step_err, 0);
        cyc("t4_down", 0, 1'b1, 1'b0, 1'b0, 0);
        chk("t4_bin8", if_a.bin_q, 8);
        chk("t4_gray8", if_a.gray_q, 4'b1100);
        cyc("t4_dir_up", 0, 1'b1, 1'b1, 1'b0, 0);
        chk("t4_bin9b", if_a.bin_q, 9);

        // 5a: saturating instance holds at both bounds.
        cyc("t5s_load", 1, 1'b0, 1'b1, 1'b1, 15);
        for (int i = 0; i < 3; i++) begin
            cyc("t5s_sat", 1, 1'b1, 1'b1, 1'b0, 0);
            chk("t5s_bin", if_s.bin_q, 15);
            chk("t5s_gray", if_s.gray_q, 4'b1000);
            chk("t5s_wrap", if_s.wrap_evt, 0);
        end
        cyc("t5s_load0", 1, 1'b0, 1'b0, 1'b1, 0);
        cyc("t5s_sat_lo", 1, 1'b1, 1'b0, 1'b0, 0);
        chk("t5s_bin_lo", if_s.bin_q, 0);

        // 5b: MAX_VAL=9 clamps loads and flags non-unit Gray wraps.
        cyc("t5n_clamp", 2, 1'b0, 1'b1, 1'b1, 12);
        chk("t5n_clamp9", if_n.bin_q, 9);
        cyc("t5n_wrap", 2, 1'b1, 1'b1, 1'b0, 0);
        chk("t5n_bin0", if_n.bin_q, 0);
        chk("t5n_wrap_pulse", if_n.wrap_evt, 1);
        chk("t5n_err_pulse", if_n.step_err, 1);
        cyc("t5n_step", 2, 1'b1, 1'b1, 1'b0, 0);
        chk("t5n_err_clear", if_n.step_err, 0);
        cyc("t5n_down", 2, 1'b1, 1'b0, 1'b0, 0);
        cyc("t5n_wrap_dn", 2, 1'b1, 1'b0, 1'b0, 0);
        chk("t5n_bin9", if_n.bin_q, 9);
        chk("t5n_err_dn", if_n.step_err, 1);

        // 6: reset mid-count with load high, then resume from 0.
        cyc("t6_load", 0, 1'b0, 1'b1, 1'b1, 5);
        cyc("t6_up", 0, 1'b1, 1'b1, 1'b0, 0);
        chk("t6_bin6", if_a.bin_q, 6);
        do_reset("t6_rst");
        chk("t6_bin0", if_a.bin_q, 0);
        cyc("t6_resume", 0, 1'b1, 1'b1, 1'b0, 0);
        chk("t6_bin1", if_a.bin_q, 1);
        chk("t6_gray1", if_a.gray_q, 4'b0001);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
